// File: rtl/debounce_bank_if.sv
// Signal bundle between raw button pins and a debounce_bank instance.
// master drives the raw buttons; slave is the debouncer producing levels and pulses.
interface debounce_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] button;
  logic [CHANNELS-1:0] debounced;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic                any_edge;

  modport master (
    output button,
    input  debounced, rise, fall, any_edge
  );

  modport slave (
    input  button,
    output debounced, rise, fall, any_edge
  );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: DEPTH-sample history per channel, sampled every DIV clocks.
// Optional macro DEBOUNCE_SYNC_EN adds a two-flop synchronizer per channel ahead of the history.
module debounce_bank #(
  parameter int CHANNELS    = 4,
  parameter int DEPTH       = 8,
  parameter int DIV         = 1,
  parameter bit RESET_LEVEL = 1'b0
) (
  input logic           clk,
  input logic           reset,
  debounce_bank_if.slave bus
);

  logic                tick;
  logic [CHANNELS-1:0] sample;
  logic [DEPTH-1:0]    hist [CHANNELS];
  logic [CHANNELS-1:0] all1;
  logic [CHANNELS-1:0] all0;
  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;

  generate
    if (DIV == 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
      logic [CW-1:0] count;

      assign tick = (count == CW'(DIV - 1));

      always_ff @(posedge clk) begin
        if (reset) begin
          count <= '0;
        end else if (tick) begin
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  endgenerate

`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= {CHANNELS{RESET_LEVEL}};
      sync2 <= {CHANNELS{RESET_LEVEL}};
    end else begin
      sync1 <= bus.button;
      sync2 <= sync1;
    end
  end

  assign sample = sync2;
`else
  assign sample = bus.button;
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        hist[i] <= {DEPTH{RESET_LEVEL}};
      end else if (tick) begin
        hist[i] <= {hist[i][DEPTH-2:0], sample[i]};
      end
    end
  end

  always_comb begin
    all1 = '0;
    all0 = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      all1[i] = &hist[i];
      all0[i] = ~|hist[i];
    end
  end

  // A pulse fires only when the accepted level actually differs from the held one.
  assign rise_nxt = all1 & ~bus.debounced;
  assign fall_nxt = all0 & bus.debounced;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.debounced <= {CHANNELS{RESET_LEVEL}};
      bus.rise      <= '0;
      bus.fall      <= '0;
      bus.any_edge  <= 1'b0;
    end else begin
      bus.debounced <= (bus.debounced | all1) & ~all0;
      bus.rise      <= rise_nxt;
      bus.fall      <= fall_nxt;
      bus.any_edge  <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: DIV=1 and DIV=4 instances driven in parallel, checked against a
// run-length reference model plus directed latency/glitch/reset scenarios.
module tb_debounce_bank;

  localparam int CH    = 4;
  localparam int DEPTH = 8;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debounce_bank_if #(.CHANNELS(CH)) bus1 ();
  debounce_bank_if #(.CHANNELS(CH)) bus4 ();

  debounce_bank #(.CHANNELS(CH), .DEPTH(DEPTH), .DIV(1), .RESET_LEVEL(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );
  debounce_bank #(.CHANNELS(CH), .DEPTH(DEPTH), .DIV(4), .RESET_LEVEL(1'b0)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference: per channel, the last accepted sample value and how many equal samples in a row.
  int            divs [2] = '{1, 4};
  int            cnt  [2];
  int            run  [2][CH];
  bit            last [2][CH];
  logic [CH-1:0] p1   [2];
  logic [CH-1:0] p2   [2];
  logic [CH-1:0] edeb [2];
  logic [CH-1:0] erise[2];
  logic [CH-1:0] efall[2];
  logic          eany [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst_v, input logic [CH-1:0] b);
    logic [CH-1:0] s;
    bit tk;
    for (int m = 0; m < 2; m++) begin
      if (rst_v) begin
        cnt[m] = 0;
        p1[m] = '0;
        p2[m] = '0;
        edeb[m] = '0;
        erise[m] = '0;
        efall[m] = '0;
        eany[m] = 1'b0;
        for (int c = 0; c < CH; c++) begin
          run[m][c] = DEPTH;
          last[m][c] = 1'b0;
        end
      end else begin
        for (int c = 0; c < CH; c++) begin
          bit stable;
          stable = (run[m][c] >= DEPTH);
          erise[m][c] = stable && last[m][c] && !edeb[m][c];
          efall[m][c] = stable && !last[m][c] && edeb[m][c];
          if (stable) edeb[m][c] = last[m][c];
        end
        eany[m] = |(erise[m] | efall[m]);
`ifdef DEBOUNCE_SYNC_EN
        s = p2[m];
        p2[m] = p1[m];
        p1[m] = b;
`else
        s = b;
`endif
        tk = (cnt[m] == divs[m] - 1);
        cnt[m] = tk ? 0 : cnt[m] + 1;
        if (tk) begin
          for (int c = 0; c < CH; c++) begin
            if (s[c] == last[m][c]) begin
              if (run[m][c] < DEPTH) run[m][c]++;
            end else begin
              last[m][c] = s[c];
              run[m][c] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic step(input logic rst_v, input logic [CH-1:0] b);
    reset = rst_v;
    bus1.button = b;
    bus4.button = b;
    @(posedge clk);
    model_update(rst_v, b);
    #1;
    check("deb1",  bus1.debounced, edeb[0]);
    check("rise1", bus1.rise,      erise[0]);
    check("fall1", bus1.fall,      efall[0]);
    check("any1",  bus1.any_edge,  eany[0]);
    check("deb4",  bus4.debounced, edeb[1]);
    check("rise4", bus4.rise,      erise[1]);
    check("fall4", bus4.fall,      efall[1]);
    check("any4",  bus4.any_edge,  eany[1]);
  endtask

  initial begin
    int f4;
    int hold [CH];
    logic [CH-1:0] b;

    // Reset with all buttons high, then one edge of released reset.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'hF);
      check("rst_deb", bus1.debounced, 0);
      check("rst_any", bus1.any_edge, 0);
    end
    step(1'b0, 4'hF);
    check("post_rst_deb", bus1.debounced, 0);
    check("post_rst_pulse", {bus1.rise, bus1.fall}, 0);
    for (int i = 0; i < 40; i++) step(1'b0, 4'h0);

    // Step on channel 0 from a fresh reset; DIV=1 at edge 9+sync, DIV=4 within a window.
    step(1'b1, 4'h0);
    f4 = 0;
    for (int e = 1; e <= 45; e++) begin
      step(1'b0, 4'h1);
      if (e == 8 + SYNC_LAT) check("step_deb_early", bus1.debounced[0], 0);
      if (e == 9 + SYNC_LAT) begin
        check("step_deb", bus1.debounced[0], 1);
        check("step_rise", bus1.rise, 4'h1);
        check("step_any", bus1.any_edge, 1);
      end
      if (e == 10 + SYNC_LAT) check("step_rise_once", {bus1.rise[0], bus1.any_edge}, 0);
      check("step_others", bus1.debounced[3:1], 0);
      if (f4 == 0 && bus4.debounced[0]) f4 = e;
    end
    check("div4_window", (f4 >= 30 && f4 <= 33 + SYNC_LAT), 1);

    // Channel 1 high for 7 clocks: rejected.
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 4'h3);
      check("glitch_any", bus1.any_edge, 0);
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 4'h1);
      check("glitch_deb1", bus1.debounced[1], 0);
      check("glitch_any", bus1.any_edge, 0);
    end

    // DIV=4: channel 0 low settled, high for 27 clocks, low again -> no change.
    for (int i = 0; i < 45; i++) step(1'b0, 4'h0);
    for (int i = 0; i < 27; i++) begin
      step(1'b0, 4'h1);
      check("div4_glitch", bus4.debounced[0], 0);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'h0);
      check("div4_glitch", {bus4.debounced[0], bus4.rise[0], bus4.fall[0]}, 0);
    end

    // Channels 2/3 settled at 1/0 then swapped together.
    for (int i = 0; i < 45; i++) step(1'b0, 4'b0100);
    for (int e = 1; e <= 12 + SYNC_LAT; e++) begin
      step(1'b0, 4'b1000);
      if (e == 9 + SYNC_LAT) begin
        check("swap_fall2", bus1.fall, 4'b0100);
        check("swap_rise3", bus1.rise, 4'b1000);
        check("swap_any", bus1.any_edge, 1);
      end else begin
        check("swap_quiet", bus1.any_edge, 0);
      end
    end

    // Reset mid-filter on a channel-0 step.
    for (int i = 0; i < 45; i++) step(1'b0, 4'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h1);
    step(1'b1, 4'h1);
    check("midrst_pulse", {bus1.rise, bus1.fall, bus1.any_edge}, 0);
    for (int e = 1; e <= 12 + SYNC_LAT; e++) begin
      step(1'b0, 4'h1);
      if (e < 9 + SYNC_LAT) check("midrst_hold", {bus1.debounced[0], bus1.any_edge}, 0);
      if (e == 9 + SYNC_LAT) check("midrst_rise", {bus1.debounced[0], bus1.rise[0]}, 2'b11);
    end

    // Randomised hold lengths mixing sub-DEPTH glitches and long settles, with rare resets.
    b = '0;
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 20);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          b[c] = ~b[c];
          hold[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, DEPTH - 1)
                                                : $urandom_range(DEPTH, 40);
        end else begin
          hold[c]--;
        end
      end
      step(($urandom_range(0, 299) == 0), b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
